// File: rtl/video_overlay_cfg_sched.sv
// Round-robin config-write arbiter into shadow registers, committed to the active overlay set on Vblank rise.
// Config/pulse outputs are registered (1 clk after the qualified edge); writes stall for the commit cycle only.
module video_overlay_cfg_sched #(
  parameter int NUM_REQ = 2,
  parameter int DW      = 12,
  parameter int RST_CX  = 960,
  parameter int RST_CY  = 540,
  parameter int RST_RO  = 300,
  parameter int RST_RI  = 150
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cen_i,
  input  logic [1:0]            vh_blank_i,
  input  logic [NUM_REQ-1:0]    req_valid_i,
  input  logic [2*NUM_REQ-1:0]  req_addr_i,
  input  logic [DW*NUM_REQ-1:0] req_data_i,
  output logic [NUM_REQ-1:0]    req_ready_o,
  output logic [DW-1:0]         center_x_o,
  output logic [DW-1:0]         center_y_o,
  output logic [DW-1:0]         r_outer_o,
  output logic [DW-1:0]         r_inner_o,
  output logic [15:0]           frame_cnt_o,
  output logic                  cfg_update_o,
  output logic                  cfg_err_o
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic              vb_d;
  logic              v_r;
  logic [PW-1:0]     rr_ptr;
  logic [PW-1:0]     gnt_idx;
  logic [PW-1:0]     rr_next;
  logic              gnt_found;
  logic [NUM_REQ-1:0] gnt_oh;
  logic [1:0]        sel_addr;
  logic [DW-1:0]     sel_data;
  logic              xfer;
  logic              commit_ok;
  logic [DW-1:0]     shadow [4];
  logic [DW-1:0]     active [4];
  logic              dirty;

  assign v_r = cen_i & vh_blank_i[1] & ~vb_d;

  // Rotating priority: offset k from rr_ptr is checked before offset k+1.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    gnt_oh    = '0;
    sel_addr  = '0;
    sel_data  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int g = 0; g < NUM_REQ; g++) begin
        if (!gnt_found && req_valid_i[g] && (((int'(rr_ptr) + k) % NUM_REQ) == g)) begin
          gnt_found = 1'b1;
          gnt_idx   = PW'(g);
          gnt_oh[g] = 1'b1;
          sel_addr  = req_addr_i[2*g +: 2];
          sel_data  = req_data_i[DW*g +: DW];
        end
      end
    end
  end

  // Reset also drops ready so a requester never sees an accept that reset discards.
  assign xfer        = gnt_found & cen_i & ~v_r & ~rst_i;
  assign req_ready_o = xfer ? gnt_oh : '0;
  assign rr_next     = (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + PW'(1);
  assign commit_ok   = shadow[3] < shadow[2];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shadow[0]    <= DW'(RST_CX);
      shadow[1]    <= DW'(RST_CY);
      shadow[2]    <= DW'(RST_RO);
      shadow[3]    <= DW'(RST_RI);
      active[0]    <= DW'(RST_CX);
      active[1]    <= DW'(RST_CY);
      active[2]    <= DW'(RST_RO);
      active[3]    <= DW'(RST_RI);
      dirty        <= 1'b0;
      rr_ptr       <= '0;
      vb_d         <= 1'b0;
      frame_cnt_o  <= '0;
      cfg_update_o <= 1'b0;
      cfg_err_o    <= 1'b0;
    end else begin
      // Pulses are refreshed every clk so they stay exactly one clk wide.
      cfg_update_o <= v_r & dirty & commit_ok;
      cfg_err_o    <= v_r & dirty & ~commit_ok;
      if (cen_i) vb_d <= vh_blank_i[1];
      if (xfer) begin
        shadow[sel_addr] <= sel_data;
        dirty            <= 1'b1;
        rr_ptr           <= rr_next;
      end
      if (v_r) begin
        frame_cnt_o <= frame_cnt_o + 16'd1;
        dirty       <= 1'b0;
        if (dirty) begin
          for (int i = 0; i < 4; i++) begin
            if (commit_ok) active[i] <= shadow[i];
            else           shadow[i] <= active[i];
          end
        end
      end
    end
  end

  assign center_x_o = active[0];
  assign center_y_o = active[1];
  assign r_outer_o  = active[2];
  assign r_inner_o  = active[3];

endmodule

// File: tb/tb_video_overlay_cfg_sched.sv
// Bench for video_overlay_cfg_sched: directed pins plus randomized traffic against a frame-level model.
module tb_video_overlay_cfg_sched;

  localparam int N  = 2;
  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          cen;
  logic [1:0]    vhb;
  logic [N-1:0]  valid;
  logic [1:0]    ra [N];
  logic [DW-1:0] rd [N];
  logic [2*N-1:0]  addr_bus;
  logic [DW*N-1:0] data_bus;
  logic [N-1:0]  ready;
  logic [DW-1:0] cx, cy, ro, ri;
  logic [15:0]   frame;
  logic          upd, err;

  assign addr_bus = {ra[1], ra[0]};
  assign data_bus = {rd[1], rd[0]};

  always #5 clk = ~clk;

  video_overlay_cfg_sched #(.NUM_REQ(N), .DW(DW)) dut (
    .clk_i(clk), .rst_i(rst), .cen_i(cen), .vh_blank_i(vhb),
    .req_valid_i(valid), .req_addr_i(addr_bus), .req_data_i(data_bus),
    .req_ready_o(ready), .center_x_o(cx), .center_y_o(cy),
    .r_outer_o(ro), .r_inner_o(ri), .frame_cnt_o(frame),
    .cfg_update_o(upd), .cfg_err_o(err)
  );

  // Behavioural model: a shadow/active register file plus frame-level bookkeeping.
  int m_sh [4];
  int m_act [4];
  int m_rst [4] = '{960, 540, 300, 150};
  bit m_dirty, m_vbd, m_upd, m_err;
  int m_ptr, m_frame;
  bit acc [N];

  int n_cmp = 0;
  int n_bad = 0;
  int dut_rdy;
  bit cen_toggle = 1'b0;

  task automatic cmp(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      if (n_bad <= 30) $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int model_grant();
    for (int k = 0; k < N; k++) begin
      int g = (m_ptr + k) % N;
      if (valid[g]) return g;
    end
    return -1;
  endfunction

  function automatic int model_ready();
    int g = model_grant();
    bit commit_now = cen && vhb[1] && !m_vbd;
    if (rst || !cen || commit_now || g < 0) return 0;
    return 1 << g;
  endfunction

  task automatic step_model();
    bit vr;
    int g;
    for (int i = 0; i < N; i++) acc[i] = 1'b0;
    if (rst) begin
      m_sh = m_rst; m_act = m_rst;
      m_dirty = 0; m_ptr = 0; m_vbd = 0; m_frame = 0; m_upd = 0; m_err = 0;
      return;
    end
    vr = cen && vhb[1] && !m_vbd;
    m_upd = 0; m_err = 0;
    if (cen && !vr) begin
      g = model_grant();
      if (g >= 0) begin
        m_sh[ra[g]] = int'(rd[g]);
        m_dirty = 1;
        m_ptr = (g + 1) % N;
        acc[g] = 1'b1;
      end
    end
    if (vr) begin
      m_frame = (m_frame + 1) & 16'hFFFF;
      if (m_dirty) begin
        if (m_sh[3] < m_sh[2]) begin m_act = m_sh; m_upd = 1; end
        else begin m_sh = m_act; m_err = 1; end
      end
      m_dirty = 0;
    end
    if (cen) m_vbd = vhb[1];
  endtask

  task automatic check();
    dut_rdy = int'(ready);
    cmp("ready", int'(ready), model_ready());
    cmp("center_x", int'(cx), m_act[0]);
    cmp("center_y", int'(cy), m_act[1]);
    cmp("r_outer", int'(ro), m_act[2]);
    cmp("r_inner", int'(ri), m_act[3]);
    cmp("frame_cnt", int'(frame), m_frame);
    cmp("cfg_update", int'(upd), int'(m_upd));
    cmp("cfg_err", int'(err), int'(m_err));
  endtask

  task automatic cyc();
    @(negedge clk);
    check();
    @(posedge clk);
    step_model();
    #1;
    if (cen_toggle) cen = ~cen;
  endtask

  task automatic send(input int g, input int a, input int d);
    bit done = 1'b0;
    ra[g] = 2'(a); rd[g] = DW'(d); valid[g] = 1'b1;
    for (int t = 0; t < 60 && !done; t++) begin
      cyc();
      done = acc[g];
    end
    if (!done) cmp("send_timeout", 0, 1);
    valid[g] = 1'b0;
  endtask

  initial begin
    int cnt [N];
    int expg;
    int fpos;
    rst = 1'b1; cen = 1'b1; vhb = 2'b00; valid = '0;
    for (int i = 0; i < N; i++) begin ra[i] = 2'd0; rd[i] = '0; end
    step_model();
    #1;
    cyc(); cyc();
    rst = 1'b0;
    // 1: reset values
    cmp("rst_cx", int'(cx), 960);
    cmp("rst_cy", int'(cy), 540);
    cmp("rst_ro", int'(ro), 300);
    cmp("rst_ri", int'(ri), 150);
    cmp("rst_frame", int'(frame), 0);
    cyc();
    cmp("rst_ready", dut_rdy, 0);

    // 2: mid-frame write held until the blanking edge
    send(0, 0, 100);
    cyc(); cyc();
    cmp("cx_before_vr", int'(cx), 960);
    vhb = 2'b10; cyc();
    cmp("cx_after_vr", int'(cx), 100);
    cmp("upd_pulse", int'(upd), 1);
    cmp("frame_one", int'(frame), 1);
    vhb = 2'b00; cyc();
    cmp("upd_one_wide", int'(upd), 0);

    // 3: two continuous requesters alternate; pointer sits at 1 after req0's grant
    ra[0] = 2'd0; rd[0] = 12'd200; ra[1] = 2'd0; rd[1] = 12'd300;
    valid = 2'b11; cnt[0] = 0; cnt[1] = 0; expg = 1;
    for (int t = 0; t < 40 && valid != 0; t++) begin
      cyc();
      for (int g = 0; g < N; g++) begin
        if (acc[g]) begin
          cmp("alt_grant", dut_rdy, 1 << expg);
          expg = 1 - expg;
          cnt[g]++;
          rd[g] = rd[g] + 12'd1;
          if (cnt[g] == 4) valid[g] = 1'b0;
        end
      end
    end
    cmp("alt_done", int'(valid), 0);
    vhb = 2'b10; cyc();
    cmp("last_writer_cx", int'(cx), 203);
    vhb = 2'b00; cyc();

    // 4: inverted radii rejected, shadow reverts
    send(0, 3, 400);
    vhb = 2'b10; cyc();
    cmp("err_pulse", int'(err), 1);
    cmp("err_no_upd", int'(upd), 0);
    cmp("err_ri_kept", int'(ri), 150);
    vhb = 2'b00; cyc();
    send(1, 2, 500);
    vhb = 2'b10; cyc();
    cmp("revert_upd", int'(upd), 1);
    cmp("revert_ri", int'(ri), 150);
    cmp("revert_ro", int'(ro), 500);
    vhb = 2'b00; cyc();

    // 5: valid held across the commit cycle
    ra[1] = 2'd2; rd[1] = 12'd310; valid[1] = 1'b1; vhb = 2'b10;
    cyc();
    cmp("stall_on_vr", dut_rdy, 0);
    cyc();
    cmp("accept_after_vr", dut_rdy, 2);
    valid[1] = 1'b0; vhb = 2'b00; cyc();
    vhb = 2'b10; cyc();
    cmp("held_ro", int'(ro), 310);
    vhb = 2'b00; cyc();

    // 6: half-rate enable, reset after a write
    cen_toggle = 1'b1;
    send(0, 2, 320);
    rst = 1'b1; cyc(); cyc(); rst = 1'b0;
    for (int f = 0; f < 3; f++) begin
      vhb = 2'b10; cyc(); cyc(); cyc();
      vhb = 2'b00; cyc(); cyc(); cyc();
    end
    cmp("rst_drop_ro", int'(ro), 300);
    cmp("cen_frames", int'(frame), 3);
    cen_toggle = 1'b0; cen = 1'b1;

    // Randomized traffic
    fpos = 0;
    for (int t = 0; t < 4000; t++) begin
      vhb[1] = (fpos % 24) >= 20;
      vhb[0] = 1'($urandom_range(0, 1));
      cen = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 499) == 0);
      for (int g = 0; g < N; g++) begin
        if (!valid[g] || acc[g]) begin
          valid[g] = ($urandom_range(0, 2) == 0);
          ra[g] = 2'($urandom_range(0, 3));
          rd[g] = DW'($urandom_range(0, 1023));
        end
      end
      cyc();
      fpos++;
    end
    rst = 1'b0; valid = '0; cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
